// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the byte-serial memory access unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_access_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int ADDR_W_DEF = 64;

    // Access size encodings: 2^size bytes per access
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam logic [1:0] MEM_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Request attributes latched at acceptance
    typedef struct packed {
        logic       op;     // 0 read, 1 write
        logic [1:0] size;
        logic       zext;   // 1 zero-extend, 0 sign-extend
    } meta_t;

    // Index of the final byte lane for a given access size
    function automatic logic [2:0] last_byte(input logic [1:0] size);
        case (size)
            MEM_B:   return 3'd0;
            MEM_H:   return 3'd1;
            MEM_W:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // True when the low address bits are not a multiple of the access size
    function automatic logic size_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return addr_lo[0];
            MEM_W:   return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of assembled little-endian load data to full width.
// Latency: combinational.
// Backpressure: none.
module mem_load_extend
    import mem_access_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] raw_dat,
    input  logic [1:0]      size,
    input  logic            zext,
    output logic [XLEN-1:0] ext_dat
);

    logic sgn;

    // Replicate the top bit of the accessed field upward, or zero-fill for unsigned loads
    always_comb begin
        ext_dat = raw_dat;
        sgn     = 1'b0;
        case (size)
            MEM_B: begin
                sgn     = raw_dat[7] & ~zext;
                ext_dat = {{(XLEN-8){sgn}}, raw_dat[7:0]};
            end
            MEM_H: begin
                sgn     = raw_dat[15] & ~zext;
                ext_dat = {{(XLEN-16){sgn}}, raw_dat[15:0]};
            end
            MEM_W: begin
                sgn     = raw_dat[31] & ~zext;
                ext_dat = {{(XLEN-32){sgn}}, raw_dat[31:0]};
            end
            default: ext_dat = raw_dat;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts core start/done memory requests into byte-serial req/ack transfers; optional trap via MEM_ACCESS_MISALIGN_TRAP_EN.
// Latency: zero-wait memory -> 2^size ACCESS cycles then one DONE cycle after the acceptance edge.
// Backpressure: each byte holds mem_req/addr/wdata until mem_ack; wait states are unbounded.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_start,
    input  logic              sel_mem_operation,
    input  logic [1:0]        sel_mem_size,
    input  logic [2:0]        sel_mem_extension,
    input  logic [ADDR_W-1:0] address,
    input  logic [XLEN-1:0]   write_data,
    output logic              memory_done,
    output logic [XLEN-1:0]   read_data,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    state_t            state_q, state_d;
    logic              armed_q;
    meta_t             meta_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        cnt_q;
    logic [XLEN-1:0]   rbuf_q, rbuf_d;
    logic [XLEN-1:0]   ext_dat;
    logic              accept, last_ack, byte_ack, trap;

    // Only funct3 bit 2 selects the extension; the low bits carry no meaning here
    logic [1:0] unused_funct3;
    assign unused_funct3 = sel_mem_extension[1:0];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap       = size_misaligned(sel_mem_size, address[2:0]);
    assign misaligned = memory_done & mis_q;
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        last_ack    = 1'b0;
        memory_done = 1'b0;
        busy        = 1'b0;
        mem_req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memory_start && armed_q) begin
                    accept  = 1'b1;
                    state_d = trap ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack && (cnt_q == last_byte(meta_q.size))) begin
                    last_ack = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                memory_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_ack  = mem_req & mem_ack;
    assign mem_we    = mem_req & meta_q.op;
    assign mem_addr  = mem_req ? (addr_q + ADDR_W'(cnt_q)) : '0;
    assign mem_wdata = mem_req ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

    // Merge the byte arriving this cycle into its lane so the final byte is usable immediately
    always_comb begin
        rbuf_d = rbuf_q;
        rbuf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
    end

    mem_load_extend #(.XLEN(XLEN)) u_extend (
        .raw_dat (rbuf_d),
        .size    (meta_q.size),
        .zext    (meta_q.zext),
        .ext_dat (ext_dat)
    );

    // Re-arm only after start is seen low, so a start held across done cannot re-trigger
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              armed_q <= 1'b1;
        else if (!memory_start) armed_q <= 1'b1;
        else if (accept)        armed_q <= 1'b0;
    end

    // Request capture, byte counter and read assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 3'd0;
            rbuf_q    <= '0;
            read_data <= '0;
        end else begin
            if (accept) begin
                meta_q  <= '{op: sel_mem_operation, size: sel_mem_size, zext: sel_mem_extension[2]};
                addr_q  <= address;
                wdata_q <= write_data;
                cnt_q   <= 3'd0;
                rbuf_q  <= '0;
            end else if (byte_ack) begin
                if (!meta_q.op) rbuf_q <= rbuf_d;
                if (!last_ack)  cnt_q  <= cnt_q + 3'd1;
            end
            if (last_ack && !meta_q.op) read_data <= ext_dat;
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Remember whether the current completion is a trap rather than a transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       mis_q <= 1'b0;
        else if (accept) mis_q <= trap;
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a wait-state memory responder.
// Latency: n/a.
// Backpressure: responder inserts a configurable number of wait cycles per byte.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_start;
    logic        sel_mem_operation;
    logic [1:0]  sel_mem_size;
    logic [2:0]  sel_mem_extension;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        memory_done;
    logic [63:0] read_data;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk               (clk),
        .reset             (reset),
        .memory_start      (memory_start),
        .sel_mem_operation (sel_mem_operation),
        .sel_mem_size      (sel_mem_size),
        .sel_mem_extension (sel_mem_extension),
        .address           (address),
        .write_data        (write_data),
        .memory_done       (memory_done),
        .read_data         (read_data),
        .busy              (busy),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        ,
        .misaligned        (misaligned)
`endif
    );

    // Byte memory responder: ack after ws wait cycles, log every accepted byte
    logic [7:0]  mem [0:255];
    int          ws = 0;
    int          wcnt = 0;
    int          req_total = 0;
    logic [63:0] log_addr [$];
    logic [7:0]  log_wd [$];
    logic        log_we [$];

    always @(negedge clk) begin
        if (mem_req) begin
            req_total = req_total + 1;
            if (wcnt >= ws) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
                log_addr.push_back(mem_addr);
                log_wd.push_back(mem_wdata);
                log_we.push_back(mem_we);
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            wcnt      = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; scramble core inputs after acceptance; return at the done cycle
    task automatic run_access(input logic op, input logic [1:0] sz, input logic [2:0] ext,
                              input logic [63:0] a, input logic [63:0] wd, input bit hold,
                              output int cyc, output int reqs, output int dones);
        int base;
        base = req_total;
        @(posedge clk); #1;
        memory_start      = 1'b1;
        sel_mem_operation = op;
        sel_mem_size      = sz;
        sel_mem_extension = ext;
        address           = a;
        write_data        = wd;
        cyc   = 0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                sel_mem_operation = ~op;
                sel_mem_size      = ~sz;
                sel_mem_extension = ~ext;
                address           = ~a;
                write_data        = ~wd;
            end
            if (memory_done) begin
                dones = 1;
                break;
            end
        end
        if (!hold) memory_start = 1'b0;
        reqs = req_total - base;
    endtask

    int cyc, reqs, dones, b;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h78; mem[8'h01] = 8'h56; mem[8'h02] = 8'h34; mem[8'h03] = 8'hF2;
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h82;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;
        mem[8'h24] = 8'h05; mem[8'h25] = 8'h06; mem[8'h26] = 8'h07; mem[8'h27] = 8'h88;
        mem[8'h40] = 8'h80; mem[8'h41] = 8'h7F; mem[8'hFF] = 8'hCD;

        reset = 1'b1; memory_start = 1'b0; sel_mem_operation = 1'b0; sel_mem_size = 2'b00;
        sel_mem_extension = 3'b000; address = '0; write_data = '0;
        #1;
        chk("rst_done", memory_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_addr", mem_addr, 0);
        #20 reset = 1'b0;

        // reset pulse while idle
        @(posedge clk); #3 reset = 1'b1; #1;
        chk("idle_rst_busy", busy, 0);
        @(negedge clk) reset = 1'b0;

        // word read, sign-extended, inputs scrambled mid-transfer
        b = log_addr.size();
        run_access(1'b0, 2'b10, 3'b000, 64'h100, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lw_done", dones, 1);
        chk("lw_latency", cyc, 5);
        chk("lw_reqs", reqs, 4);
        chk("lw_busy_done", busy, 1);
        chk("lw_data", read_data, 64'hFFFFFFFF_F2345678);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("lw_nomis", misaligned, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw_addr%0d", k), log_addr[b+k], 64'h100 + 64'(k));
            chk($sformatf("lw_we%0d", k), log_we[b+k], 0);
        end
        @(posedge clk); #1;
        chk("lw_done_pulse", memory_done, 0);
        chk("lw_idle_busy", busy, 0);

        // byte reads: signed then unsigned
        run_access(1'b0, 2'b00, 3'b000, 64'h40, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lb_latency", cyc, 2);
        chk("lb_data", read_data, 64'hFFFFFFFF_FFFFFF80);
        run_access(1'b0, 2'b00, 3'b100, 64'h40, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lbu_data", read_data, 64'h00000000_00000080);

        // halfword signed/unsigned, unsigned word, doubleword without extension
        run_access(1'b0, 2'b01, 3'b001, 64'h10, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lh_data", read_data, 64'hFFFFFFFF_FFFF8234);
        run_access(1'b0, 2'b01, 3'b101, 64'h10, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lhu_data", read_data, 64'h00000000_00008234);
        run_access(1'b0, 2'b10, 3'b110, 64'h100, 64'h0, 1'b0, cyc, reqs, dones);
        chk("lwu_data", read_data, 64'h00000000_F2345678);
        run_access(1'b0, 2'b11, 3'b011, 64'h20, 64'h0, 1'b0, cyc, reqs, dones);
        chk("ld_reqs", reqs, 8);
        chk("ld_data", read_data, 64'h88070605_04030201);

        // doubleword write with two wait states per byte
        ws = 2;
        b = log_addr.size();
        run_access(1'b1, 2'b11, 3'b011, 64'h8, 64'h11223344_55667788, 1'b0, cyc, reqs, dones);
        chk("sd_done", dones, 1);
        chk("sd_reqs", reqs, 24);
        chk("sd_latency", cyc, 25);
        chk("sd_rdata_kept", read_data, 64'h88070605_04030201);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sd_addr%0d", k), log_addr[b+k], 64'h8 + 64'(k));
            chk($sformatf("sd_wd%0d", k), log_wd[b+k], 64'h88 - 64'(k) * 64'h11);
            chk($sformatf("sd_we%0d", k), log_we[b+k], 1);
        end
        ws = 0;

        // start held across done: no retrigger until it drops
        run_access(1'b0, 2'b00, 3'b100, 64'h40, 64'h0, 1'b1, cyc, reqs, dones);
        chk("hold_first", read_data, 64'h80);
        b = req_total;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_busy%0d", k), busy, 0);
        end
        chk("hold_reqs", req_total - b, 0);
        memory_start = 1'b0;
        run_access(1'b0, 2'b00, 3'b000, 64'h41, 64'h0, 1'b0, cyc, reqs, dones);
        chk("hold_rearm", read_data, 64'h7F);

`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
        // misaligned halfword wrapping past the top of the address space
        b = log_addr.size();
        run_access(1'b0, 2'b01, 3'b101, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, cyc, reqs, dones);
        chk("wrap_data", read_data, 64'h78CD);
        chk("wrap_addr0", log_addr[b], 64'hFFFFFFFF_FFFFFFFF);
        chk("wrap_addr1", log_addr[b+1], 64'h0);
`else
        // misaligned halfword traps without memory traffic
        run_access(1'b0, 2'b01, 3'b000, 64'h101, 64'h0, 1'b0, cyc, reqs, dones);
        chk("mis_latency", cyc, 1);
        chk("mis_reqs", reqs, 0);
        chk("mis_flag", misaligned, 1);
        chk("mis_rdata_kept", read_data, 64'h7F);
        @(posedge clk); #1;
        chk("mis_flag_clr", misaligned, 0);
`endif

        // reset in the middle of a slow transfer
        ws = 5;
        @(posedge clk); #1;
        memory_start = 1'b1; sel_mem_operation = 1'b0; sel_mem_size = 2'b11; address = 64'h20;
        @(posedge clk); #1;
        chk("mid_req", mem_req, 1);
        #3 reset = 1'b1; #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", memory_done, 0);
        chk("mid_rst_rdata", read_data, 0);
        memory_start = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req", mem_req, 0);
        ws = 0;
        run_access(1'b0, 2'b00, 3'b000, 64'h41, 64'h0, 1'b0, cyc, reqs, dones);
        chk("post_rst_read", read_data, 64'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
